// File: rtl/gf_poly_eval.sv
// Sequential Horner evaluator for a flattened GF(2^SIZE) polynomial of degree large_array.
// One coefficient per clock through a single shared gf_mul, with valid/ready on both sides.

module gf_mul #(
    parameter int m    = 255,
    parameter int SIZE = $clog2(m)
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE-1:0] p
);
    // Primitive polynomial chosen from the field order; the x^SIZE term is implicit.
    function automatic int poly_for(input int order);
        case (order)
            7:       return 'h00B;
            15:      return 'h013;
            31:      return 'h025;
            63:      return 'h043;
            127:     return 'h089;
            default: return 'h11D;
        endcase
    endfunction

    localparam int              POLY_INT = poly_for(m);
    localparam logic [SIZE-1:0] POLY_LOW = SIZE'(POLY_INT);

    logic [SIZE-1:0] aa;
    logic [SIZE-1:0] prod;
    logic            carry;

    always_comb begin
        prod  = '0;
        aa    = a;
        carry = 1'b0;
        for (int i = 0; i < SIZE; i++) begin
            if (b[i]) prod = prod ^ aa;
            carry = aa[SIZE-1];
            aa    = {aa[SIZE-2:0], 1'b0} ^ (carry ? POLY_LOW : '0);
        end
    end

    assign p = prod;
endmodule

module gf_poly_eval #(
    parameter int m           = 255,
    parameter int SIZE        = $clog2(m),
    parameter int n           = 2,
    parameter int large_array = 2 * n,
    parameter int flat_size   = (large_array + 1) * SIZE
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [flat_size-1:0] flat_p,
    input  logic [SIZE-1:0]      x,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SIZE-1:0]      y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);
    localparam int IDX_W = $clog2(large_array + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [flat_size-1:0] flat_reg;
    logic [SIZE-1:0]      x_reg;
    logic [SIZE-1:0]      acc;
    logic [SIZE-1:0]      acc_nxt;
    logic [SIZE-1:0]      prod;
    logic [SIZE-1:0]      coef;
    logic [SIZE-1:0]      y_reg;
    logic [IDX_W-1:0]     idx;
    logic                 out_valid_reg;
    logic                 busy_reg;

    gf_mul #(.m(m), .SIZE(SIZE)) u_mul (
        .a(acc),
        .b(x_reg),
        .p(prod)
    );

    assign coef    = flat_reg[int'(idx)*SIZE +: SIZE];
    assign acc_nxt = prod ^ coef;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = RUN;
            RUN:     if (idx == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Job operands are captured once at accept and held for the whole evaluation.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            flat_reg <= flat_p;
            x_reg    <= x;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            acc           <= '0;
            y_reg         <= '0;
            idx           <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state         <= state_nxt;
            out_valid_reg <= (state_nxt == DONE);
            busy_reg      <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc <= '0;
                        idx <= IDX_W'(large_array);
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (idx == '0) y_reg <= acc_nxt;
                    else           idx   <= idx - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign y         = y_reg;
endmodule

// File: tb/tb_gf_poly_eval.sv
// Randomized and directed bench for gf_poly_eval against a power-sum GF(2^8) reference model.

module tb_gf_poly_eval;
    localparam int SZ = 8;
    localparam int LA = 4;
    localparam int FS = (LA + 1) * SZ;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [FS-1:0] flat_p = '0;
    logic [SZ-1:0] x = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [SZ-1:0] y;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;

    int checks = 0;
    int errors = 0;

    gf_poly_eval #(.m(255), .SIZE(SZ), .n(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flat_p(flat_p),
        .x(x),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .y(y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x^2+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] t;
        logic [15:0] pp;
        t = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) t = t ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) begin
            pp = 16'h011D;
            if (t[i]) t = t ^ (pp << (i - 8));
        end
        return t[7:0];
    endfunction

    // p(x) = sum over k of coef[k] * x^k
    function automatic logic [7:0] ref_eval(input logic [FS-1:0] fp, input logic [7:0] xv);
        logic [7:0] r;
        logic [7:0] xp;
        r  = '0;
        xp = 8'h01;
        for (int k = 0; k <= LA; k++) begin
            r  = r ^ ref_mul(fp[k*SZ +: SZ], xp);
            xp = ref_mul(xp, xv);
        end
        return r;
    endfunction

    task automatic start_job(input logic [FS-1:0] fp, input logic [7:0] xv);
        @(negedge clk);
        flat_p   = fp;
        x        = xv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flat_p   = FS'({$urandom(), $urandom()});
        x        = 8'($urandom());
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_job(input string tag, input logic [FS-1:0] fp, input logic [7:0] xv,
                           input logic [7:0] exp_y, input int stall);
        int cyc;
        out_ready = 1'b0;
        start_job(fp, xv);
        check({tag, "_busy"}, busy, 1);
        wait_done(cyc);
        check({tag, "_lat"}, cyc, 5);
        check({tag, "_y"}, y, exp_y);
        repeat (stall) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_idle"}, {out_valid, in_ready, busy}, 3'b010);
    endtask

    initial begin
        int cyc;
        int saw;
        logic [FS-1:0] fp;
        logic [7:0]    xv;

        // Reset and idle
        #3 rst_n = 1'b0;
        #1;
        check("rst_outs", {in_ready, out_valid, busy}, 3'b100);
        check("rst_y", y, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0 || i == 9)
                check("idle_outs", {in_ready, out_valid, busy, y}, {3'b100, 8'h00});
        end

        run_job("x1_sum", {8'h10, 8'h08, 8'h04, 8'h02, 8'h01}, 8'h01, 8'h1F, 0);
        run_job("x0", {8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'hA5}, 8'h00, 8'hA5, 0);
        run_job("p1", {8'h00, 8'h00, 8'h00, 8'h01, 8'h00}, 8'h02, 8'h02, 0);
        run_job("p2", {8'h00, 8'h00, 8'h01, 8'h00, 8'h00}, 8'h02, 8'h04, 1);
        run_job("zero", '0, 8'h57, 8'h00, 0);

        // Backpressure with a stray in_valid during the stall
        out_ready = 1'b0;
        start_job({5{8'hFF}}, 8'h01);
        wait_done(cyc);
        check("bp_y0", y, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = (i == 2);
            flat_p   = {5{8'h33}};
            check("bp_hold", {y, out_valid, in_ready, busy}, {8'hFF, 3'b101});
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {out_valid, in_ready, busy}, 3'b010);
        repeat (3) @(posedge clk);
        #1;
        check("bp_nojob", {busy, y}, {1'b0, 8'hFF});

        // Reset in the middle of a run
        start_job({5{8'h77}}, 8'h03);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst", {in_ready, out_valid, busy, y}, {3'b100, 8'h00});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) saw++;
        end
        check("mid_rst_noval", saw, 0);
        run_job("after_rst", {8'h00, 8'h00, 8'h00, 8'h00, 8'h11}, 8'h01, 8'h11, 0);

        // Randomized jobs with random backpressure
        for (int t = 0; t < 30; t++) begin
            fp = FS'({$urandom(), $urandom()});
            xv = 8'($urandom());
            run_job("rand", fp, xv, ref_eval(fp, xv), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
